exu_div_seq_ctl: RTL and testbench

- Sequencer plus radix-2 restoring datapath for the shared RV64M iterative divider.
- Accepts one divide request from the i0 execute pipe in the form of the div_pkt_t fields (valid, unsign, rem, word).
- Runs the request for a fixed number of cycles, then returns a single 64-bit result pulse to the writeback arbiter.
- Holds busy so decode stalls any further divides; handles pipeline cancel and the RISC-V special cases.

---
 rtl/exu_div_seq_ctl.sv | 190 +++++++++++++++++++
 tb/tb_exu_div_seq_ctl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_seq_ctl.sv
// Sequencer and radix-2 restoring datapath for the shared RV64M iterative divider.
// One request at a time: operands are captured on accept, fixed up in PREP,
// iterated one quotient bit per cycle, sign-corrected in FIX and strobed out in DONE.
//
// state | meaning
// IDLE  | waiting for a request, div_busy low
// PREP  | operand fixup (W extension, magnitudes), special-case detect, counter load
// ITER  | one restoring step per cycle until the counter reaches zero
// FIX   | sign correction, quotient/remainder select, W sign extension
// DONE  | out_valid strobe, returns to IDLE unconditionally
module exu_div_seq_ctl #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  input  logic            div_unsign,
  input  logic            div_rem,
  input  logic            div_word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_cancel,
  output logic            div_busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // captured request
  logic [XLEN-1:0] a_q, b_q;
  logic            unsign_q, rem_sel_q, word_q;

  // iteration registers
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dmag_q;
  logic [CW-1:0]   cnt_q;
  logic            q_neg_q, r_neg_q;
  logic [XLEN-1:0] out_q;

  logic accept;

  // operand fixup (valid while in PREP, a_q/b_q stable since accept)
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, special_raw, special_res;
  logic            a_neg, b_neg, div_zero, ovf, special;

  // restoring step
  logic [XLEN:0]   shifted;
  logic            step_ge;
  logic [XLEN-1:0] rem_step;

  // final result
  logic [XLEN-1:0] quo_fix, rem_fix, sel_res, fix_res;

  assign accept = div_valid && (state_q == IDLE) && !div_cancel;

  // operand extension, magnitudes and RISC-V special-case detection
  always_comb begin
    if (word_q) begin
      a_ext   = unsign_q ? {{(XLEN-WLEN){1'b0}}, a_q[WLEN-1:0]}
                         : {{(XLEN-WLEN){a_q[WLEN-1]}}, a_q[WLEN-1:0]};
      b_ext   = unsign_q ? {{(XLEN-WLEN){1'b0}}, b_q[WLEN-1:0]}
                         : {{(XLEN-WLEN){b_q[WLEN-1]}}, b_q[WLEN-1:0]};
      min_val = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end else begin
      a_ext   = a_q;
      b_ext   = b_q;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = !unsign_q && a_ext[XLEN-1];
    b_neg    = !unsign_q && b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    ovf      = !unsign_q && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || ovf;
    // MIN / -1 : quotient is the dividend itself (MIN), remainder 0
    if (div_zero)
      special_raw = rem_sel_q ? a_ext : '1;
    else
      special_raw = rem_sel_q ? '0 : a_ext;
    special_res = word_q ? {{(XLEN-WLEN){special_raw[WLEN-1]}}, special_raw[WLEN-1:0]}
                         : special_raw;
  end

  // one restoring step: compare instead of subtract-then-test to keep widths tight
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    step_ge  = (shifted >= {1'b0, dmag_q});
    rem_step = step_ge ? (shifted[XLEN-1:0] - dmag_q) : shifted[XLEN-1:0];
  end

  // sign correction and result select
  always_comb begin
    quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    sel_res = rem_sel_q ? rem_fix : quo_fix;
    fix_res = word_q ? {{(XLEN-WLEN){sel_res[WLEN-1]}}, sel_res[WLEN-1:0]} : sel_res;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: cancel beats everything except reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = PREP;
      PREP: state_d = special ? DONE : ITER;
      ITER: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (div_cancel && state_q != IDLE) state_d = IDLE;
  end

  // outputs: busy whenever a request is owned; strobe only in DONE (cancel there is killed downstream)
  always_comb begin
    div_busy  = (state_q != IDLE);
    out_valid = (state_q == DONE);
    out       = out_q;
  end

  // datapath registers; out_q only moves on the way into DONE so it holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      unsign_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dmag_q    <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q       <= dividend;
            b_q       <= divisor;
            unsign_q  <= div_unsign;
            rem_sel_q <= div_rem;
            word_q    <= div_word;
          end
        end
        PREP: begin
          // word ops park the 32-bit magnitude in the top half so the MSB-first
          // shift sees it immediately and the quotient lands in the low half
          quo_q   <= word_q ? {a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag;
          rem_q   <= '0;
          dmag_q  <= b_mag;
          cnt_q   <= word_q ? CW'(WLEN - 1) : CW'(XLEN - 1);
          q_neg_q <= a_neg ^ b_neg;
          r_neg_q <= a_neg;
          if (special && !div_cancel) out_q <= special_res;
        end
        ITER: begin
          quo_q <= {quo_q[XLEN-2:0], step_ge};
          rem_q <= rem_step;
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          if (!div_cancel) out_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_div_seq_ctl.sv
// Self-checking bench for exu_div_seq_ctl: directed cases plus random ops
// compared against an arithmetic reference of the RV64M divide rules.
module tb_exu_div_seq_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid, div_unsign, div_rem, div_word, div_cancel;
  logic [63:0] dividend, divisor;
  logic        div_busy, out_valid;
  logic [63:0] out;

  int n_pass  = 0;
  int n_total = 0;
  int op_id   = 0;

  always #5 clk = ~clk;

  exu_div_seq_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_unsign (div_unsign),
    .div_rem    (div_rem),
    .div_word   (div_word),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_cancel (div_cancel),
    .div_busy   (div_busy),
    .out_valid  (out_valid),
    .out        (out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s op=%0d observed=%h expected=%h", tag, op_id, obs, exp);
  endtask

  function automatic logic [63:0] ext_op(input logic [63:0] v, input logic u, input logic w);
    if (!w) return v;
    return u ? {32'h0, v[31:0]} : {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                              input logic u, input logic r, input logic w);
    logic [63:0] ua, ub, res;
    longint sa, sb;
    ua = ext_op(a, u, w);
    ub = ext_op(b, u, w);
    sa = ua;
    sb = ub;
    if (ub == 64'd0)                          res = r ? ua : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (u)                               res = r ? (ua % ub) : (ua / ub);
    else if (ua == 64'h8000_0000_0000_0000 && sb == -1) res = r ? 64'd0 : ua;
    else                                      res = r ? 64'(sa % sb) : 64'(sa / sb);
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b,
                                     input logic u, input logic w);
    logic [63:0] ua, ub;
    ua = ext_op(a, u, w);
    ub = ext_op(b, u, w);
    if (ub == 64'd0) return 2;
    if (!u && ub == 64'hFFFF_FFFF_FFFF_FFFF &&
        ua == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 2;
    return w ? 35 : 67;
  endfunction

  // Launch at the next negedge; returns one step into cycle T+1.
  task automatic launch(input logic [63:0] a, input logic [63:0] b,
                        input logic u, input logic r, input logic w);
    @(negedge clk);
    dividend = a; divisor = b; div_unsign = u; div_rem = r; div_word = w;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  // Full op with timing checks. hold=1 keeps div_valid high with fresh operands while busy.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic u, input logic r, input logic w, input bit hold);
    logic [63:0] exp;
    int lat;
    bit early, busy_drop;
    exp = ref_result(a, b, u, r, w);
    lat = ref_latency(a, b, u, w);
    early = 0; busy_drop = 0;
    op_id++;
    launch(a, b, u, r, w);
    if (hold) begin
      div_valid = 1'b1;
      dividend  = {$urandom, $urandom};
      divisor   = 64'd3;
      div_word  = 1'b0;
    end
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) chk("busy_start", 64'(div_busy), 64'd1);
      if (k <= lat && !div_busy) busy_drop = 1;
      if (k < lat && out_valid) early = 1;
      if (k == lat) begin
        chk("valid_at_lat", 64'(out_valid), 64'd1);
        chk("result", out, exp);
        div_valid = 1'b0;
      end
      if (k == lat + 1) begin
        chk("busy_end", 64'(div_busy), 64'd0);
        chk("valid_end", 64'(out_valid), 64'd0);
      end
    end
    chk("no_early_valid", 64'(early), 64'd0);
    chk("busy_held", 64'(busy_drop), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [63:0] ra, rb;
    logic ru, rr, rw;
    rst = 1'b1;
    div_valid = 0; div_unsign = 0; div_rem = 0; div_word = 0; div_cancel = 0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(div_busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    @(negedge clk); rst = 1'b0;

    // directed cases
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0, 0, 0);           // DIV -7/2
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1, 0, 0);           // REM -7%2
    run_op(64'h0000_0000_FFFF_FFFE, 64'd1, 1, 0, 1, 0);           // DIVUW
    run_op(64'd5, 64'd0, 0, 0, 0, 0);                             // DIV by zero
    run_op(64'd5, 64'd0, 0, 1, 0, 0);                             // REM by zero
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1, 1, 0); // REMW ovf
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0, 1, 0); // DIVW ovf
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0); // DIV ovf
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1, 1, 0, 0);           // REMU max
    run_op(64'h1234_5678_0000_0005, 64'd0, 1, 1, 1, 0);           // REMUW by zero

    // cancel mid-ITER at T+20, new request at T+21
    op_id++;
    launch(64'd1000, 64'd3, 0, 0, 0);
    repeat (19) begin @(posedge clk); #1; end
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    chk("cancel_busy", 64'(div_busy), 64'd0);
    chk("cancel_valid", 64'(out_valid), 64'd0);
    run_op(64'd100, 64'd7, 0, 0, 0, 0);

    // cancel in the same cycle as the request
    op_id++;
    @(negedge clk);
    dividend = 64'd9; divisor = 64'd2; div_valid = 1'b1; div_cancel = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; div_cancel = 1'b0;
    chk("samecyc_cancel_busy", 64'(div_busy), 64'd0);

    // cancel during DONE: strobe still visible
    op_id++;
    launch(64'd5, 64'd0, 0, 0, 0);
    @(posedge clk); #1;
    div_cancel = 1'b1;
    chk("done_cancel_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    div_cancel = 1'b0;
    chk("done_cancel_busy", 64'(div_busy), 64'd0);

    // div_valid held high while busy: only the first request runs
    run_op(64'd12345, 64'd100, 1, 0, 0, 1);
    run_op(64'hFFFF_FFFF_FFFF_FF00, 64'd9, 0, 1, 1, 1);

    // reset mid-operation at T+10
    op_id++;
    launch(64'd777, 64'd5, 1, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(div_busy), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", out, 64'd0);
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid || div_busy) seen = 1; end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    // random ops
    for (int i = 0; i < 24; i++) begin
      ru = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0)
        ra = rw ? {ra[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
      case ($urandom_range(0, 3))
        0: rb = 64'd0;
        1: rb = 64'($urandom_range(1, 15));
        2: rb = {$urandom, $urandom};
        default: rb = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      run_op(ra, rb, ru, rr, rw, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
